spi_rx_multi: RTL and testbench

Parametrised successor to the single-channel SPI receive master in the voltmeter datapath. Reads one frame of BITS bits from one of CHANNELS SPI ADCs sharing sclk/miso, each with its own active-low select. Adds a programmable sclk divider, a selectable SPI mode, programmable lead and gap timing, and a tagged output with a valid strobe for the display and averaging logic downstream.

---
 rtl/spi_rx_multi_if.sv | 40 ++++
 rtl/spi_rx_multi.sv | 190 +++++++++++++++++++
 tb/tb_spi_rx_multi.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_rx_multi_if.sv
// spi_rx_multi_if: control, SPI pins and result bundle of spi_rx_multi.
// SPI_RX_MOSI_EN adds the tx_word/mosi transmit signals.
interface spi_rx_multi_if #(
    parameter int BITS     = 16,
    parameter int CHANNELS = 2
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                en;
    logic [CW-1:0]       ch_sel;
    logic                miso;
    logic [CHANNELS-1:0] ss_n;
    logic                sclk;
    logic                busy;
    logic                data_valid;
    logic [CW-1:0]       data_ch;
    logic [BITS-1:0]     data_rec;
`ifdef SPI_RX_MOSI_EN
    logic [BITS-1:0]     tx_word;
    logic                mosi;

    modport master (
        input  en, ch_sel, miso, tx_word,
        output ss_n, sclk, busy, data_valid, data_ch, data_rec, mosi
    );
    modport slave (
        output en, ch_sel, miso, tx_word,
        input  ss_n, sclk, busy, data_valid, data_ch, data_rec, mosi
    );
`else
    modport master (
        input  en, ch_sel, miso,
        output ss_n, sclk, busy, data_valid, data_ch, data_rec
    );
    modport slave (
        output en, ch_sel, miso,
        input  ss_n, sclk, busy, data_valid, data_ch, data_rec
    );
`endif
endinterface

// File: rtl/spi_rx_multi.sv
// spi_rx_multi: multi-channel SPI receive master with divider, mode, lead/gap.
// Define SPI_RX_MOSI_EN to add the tx_word/mosi transmit path.
module spi_rx_multi #(
    parameter int BITS     = 16,
    parameter int CHANNELS = 2,
    parameter int CLK_DIV  = 6,
    parameter int LEAD     = 2,
    parameter int GAP      = 2,
    parameter bit CPOL     = 1'b1,
    parameter bit CPHA     = 1'b0
) (
    input logic            clk,
    input logic            rst,
    spi_rx_multi_if.master bus
);
    localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int HALF = CLK_DIV / 2;
    localparam int LG   = (LEAD > GAP) ? LEAD : GAP;
    localparam int MAXC = (LG > CLK_DIV) ? LG : CLK_DIV;
    localparam int TW   = $clog2(MAXC + 1);
    localparam int BW   = $clog2(BITS + 1);

    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [TW-1:0] LEAD_END = TW'(LEAD - 1);
    localparam logic [TW-1:0] GAP_END  = TW'(GAP - 1);
    localparam logic [TW-1:0] DIV_END  = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] HALF_T   = TW'(HALF);
    // Sample on the leading edge (CPHA=0) or the trailing edge (CPHA=1)
    localparam logic [TW-1:0] SAMP_AT  = CPHA ? DIV_END : TW'(HALF - 1);
    localparam logic [BW-1:0] B_ONE    = BW'(1);
    localparam logic [BW-1:0] BITS_B   = BW'(BITS);
    localparam logic [CW:0]   CH_LIM   = (CW + 1)'(CHANNELS);
    localparam logic [CW-1:0] CH_MAX   = CW'(CHANNELS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEAD,
        S_XFER,
        S_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [TW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [CW-1:0]       ch_q, ch_d;
    logic [BITS-1:0]     sh_q, sh_d;
    logic [CHANNELS-1:0] ss_n_q, ss_n_d;
    logic                sclk_q, sclk_d;
    logic                dv_q, dv_d;
    logic [CW-1:0]       dch_q, dch_d;
    logic [BITS-1:0]     drec_q, drec_d;
    logic                samp;
    logic                sel;
`ifdef SPI_RX_MOSI_EN
    localparam logic [TW-1:0] DRIVE_AT = CPHA ? TW'(HALF - 1) : DIV_END;
    logic [BITS-1:0]     tx_q, tx_d;
    logic                drive;
`endif

    // State register and all registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            ch_q    <= '0;
            sh_q    <= '0;
            ss_n_q  <= '1;
            sclk_q  <= CPOL;
            dv_q    <= 1'b0;
            dch_q   <= '0;
            drec_q  <= '0;
`ifdef SPI_RX_MOSI_EN
            tx_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            ch_q    <= ch_d;
            sh_q    <= sh_d;
            ss_n_q  <= ss_n_d;
            sclk_q  <= sclk_d;
            dv_q    <= dv_d;
            dch_q   <= dch_d;
            drec_q  <= drec_d;
`ifdef SPI_RX_MOSI_EN
            tx_q    <= tx_d;
`endif
        end
    end

    // Next state, sclk phase, sampling and frame hand-off
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        ch_d    = ch_q;
        sh_d    = sh_q;
        dv_d    = 1'b0;
        dch_d   = dch_q;
        drec_d  = drec_q;
        ss_n_d  = '1;
        sclk_d  = CPOL;
        sel     = 1'b0;
        samp    = (state_q == S_XFER) && (cnt_q == SAMP_AT);
`ifdef SPI_RX_MOSI_EN
        tx_d    = tx_q;
        // Shift only after a sample so the MSB survives a CPHA=1 lead edge
        drive   = (state_q == S_XFER) && (cnt_q == DRIVE_AT)
                  && (bit_q != BITS_B);
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.en) begin
                    state_d = S_LEAD;
                    cnt_d   = '0;
                    bit_d   = BITS_B;
                    ch_d    = ({1'b0, bus.ch_sel} >= CH_LIM)
                              ? CH_MAX : bus.ch_sel;
`ifdef SPI_RX_MOSI_EN
                    tx_d    = bus.tx_word;
`endif
                end
            end
            S_LEAD: begin
                if (cnt_q == LEAD_END) begin
                    state_d = S_XFER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + T_ONE;
                end
            end
            S_XFER: begin
                if (samp) begin
                    sh_d  = {sh_q[BITS-2:0], bus.miso};
                    bit_d = bit_q - B_ONE;
                end
`ifdef SPI_RX_MOSI_EN
                if (drive) begin
                    tx_d = {tx_q[BITS-2:0], 1'b0};
                end
`endif
                if (cnt_q == DIV_END) begin
                    cnt_d = '0;
                    // Last period back at CPOL: hand the frame over
                    if (bit_d == '0) begin
                        state_d = S_GAP;
                        dv_d    = 1'b1;
                        dch_d   = ch_q;
                        drec_d  = sh_d;
                    end
                end else begin
                    cnt_d = cnt_q + T_ONE;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_END) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + T_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        sel = (state_d == S_LEAD) || (state_d == S_XFER);
        for (int i = 0; i < CHANNELS; i++) begin
            ss_n_d[i] = !(sel && (ch_d == CW'(i)));
        end
        if ((state_d == S_XFER) && (cnt_d >= HALF_T)) begin
            sclk_d = ~CPOL;
        end
    end

    assign bus.ss_n       = ss_n_q;
    assign bus.sclk       = sclk_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.data_valid = dv_q;
    assign bus.data_ch    = dch_q;
    assign bus.data_rec   = drec_q;
`ifdef SPI_RX_MOSI_EN
    assign bus.mosi = ((state_q == S_LEAD) || (state_q == S_XFER))
                      ? tx_q[BITS-1] : 1'b0;
`endif

endmodule

// File: tb/tb_spi_rx_multi.sv
// tb_spi_rx_multi: directed bench for spi_rx_multi (defaults, mode sweep,
// single channel, optional SPI_RX_MOSI_EN transmit path).
module tb_spi_rx_multi;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- default instance, two channels ----------------
    spi_rx_multi_if #(.BITS(16), .CHANNELS(2)) mif ();
    spi_rx_multi u_main (.clk(clk), .rst(rst), .bus(mif));

    logic [15:0] m_word [2];
    int   m_idx = 15;
    logic m_prev = 1'b1;
    int   m_dv = 0;
`ifdef SPI_RX_MOSI_EN
    logic [15:0] m_mosi_seq = '0;
    int   m_mosi_bad = 0;
`endif

    // ADC model for CPOL=1/CPHA=0: next bit after each rising sclk
    always @(negedge clk) begin
        if (mif.data_valid) m_dv++;
        if (&mif.ss_n) m_idx = 15;
        else if (mif.sclk && !m_prev) m_idx--;
`ifdef SPI_RX_MOSI_EN
        if (!mif.sclk && m_prev) m_mosi_seq = {m_mosi_seq[14:0], mif.mosi};
        if (!mif.busy && mif.mosi) m_mosi_bad++;
`endif
        m_prev = mif.sclk;
        mif.miso = (m_idx >= 0) ? m_word[mif.ss_n[1] ? 0 : 1][m_idx] : 1'b0;
    end

    // ---------------- single channel instance ----------------
    spi_rx_multi_if #(.BITS(16), .CHANNELS(1)) oif ();
    spi_rx_multi #(.BITS(16), .CHANNELS(1)) u_one (
        .clk(clk), .rst(rst), .bus(oif)
    );

    logic [15:0] o_word = 16'h3C96;
    int   o_idx = 15;
    logic o_prev = 1'b1;
    int   o_dv = 0;

    always @(negedge clk) begin
        if (oif.data_valid) o_dv++;
        if (oif.ss_n[0]) o_idx = 15;
        else if (oif.sclk && !o_prev) o_idx--;
        o_prev = oif.sclk;
        oif.miso = (o_idx >= 0) ? o_word[o_idx] : 1'b0;
    end

    // ---------------- CPOL/CPHA sweep, BITS=12 CLK_DIV=4 ----------------
    logic        sw_en = 1'b0;
    logic [11:0] sw_rec [4];
    int          sw_dv [4];
    int          sw_edge [4];
    int          sw_bad [4];
    logic [3:0]  sw_busy;
    logic [3:0]  sw_sclk;

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam bit CP = (g >= 2);
        localparam bit CH = (g % 2 == 1);
        spi_rx_multi_if #(.BITS(12), .CHANNELS(2)) u_if ();
        spi_rx_multi #(
            .BITS(12), .CHANNELS(2), .CLK_DIV(4), .LEAD(2), .GAP(2),
            .CPOL(CP), .CPHA(CH)
        ) u_dut (.clk(clk), .rst(rst), .bus(u_if));

        logic [11:0] word = 12'h5A3;
        int   idx = CH ? 12 : 11;
        int   dv = 0;
        int   edges = 0;
        int   bad = 0;
        logic prev = CP;
        logic lead;

        assign u_if.en     = sw_en;
        assign u_if.ch_sel = 1'b0;
`ifdef SPI_RX_MOSI_EN
        assign u_if.tx_word = 12'h000;
`endif
        assign sw_rec[g]  = u_if.data_rec;
        assign sw_dv[g]   = dv;
        assign sw_edge[g] = edges;
        assign sw_bad[g]  = bad;
        assign sw_busy[g] = u_if.busy;
        assign sw_sclk[g] = u_if.sclk;

        // Generic ADC model: drives on the non-sample edge, counts sample edges
        always @(negedge clk) begin
            if (u_if.data_valid) dv++;
            if (!u_if.busy && (u_if.sclk != CP)) bad++;
            if (u_if.sclk != prev) begin
                lead = (u_if.sclk != CP);
                if (lead != CH) edges++;
                if (!(&u_if.ss_n) && (lead == CH)) idx--;
            end
            if (&u_if.ss_n) idx = CH ? 12 : 11;
            prev = u_if.sclk;
            u_if.miso = (idx >= 0 && idx < 12) ? word[idx] : 1'b0;
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mif.ss_n !== 2'b11) begin
            errors++; $display("FAIL reset_ss_n: got %b want 11", mif.ss_n);
        end
        checks++;
        if (mif.sclk !== 1'b1) begin
            errors++; $display("FAIL reset_sclk: got %b want 1", mif.sclk);
        end
        checks++;
        if (mif.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", mif.busy);
        end
        checks++;
        if (mif.data_valid !== 1'b0) begin
            errors++; $display("FAIL reset_dv: got %b want 0", mif.data_valid);
        end
        checks++;
        if (mif.data_ch !== 1'b0) begin
            errors++; $display("FAIL reset_ch: got %h want 0", mif.data_ch);
        end
        checks++;
        if (mif.data_rec !== 16'h0000) begin
            errors++; $display("FAIL reset_rec: got %h want 0000", mif.data_rec);
        end
`ifdef SPI_RX_MOSI_EN
        checks++;
        if (mif.mosi !== 1'b0) begin
            errors++; $display("FAIL reset_mosi: got %b want 0", mif.mosi);
        end
`endif
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lo = 0;
        int gap = 0;
        int dv0;
        bit seen = 0;
        bit done = 0;
        bit bad_ss = 0;
        m_word[1] = 16'hA5C3;
        dv0 = m_dv;
        @(negedge clk);
        mif.ch_sel = 1'b1;
        mif.en = 1'b1;
        @(negedge clk);
        mif.en = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            if (mif.ss_n == 2'b01) lo++;
            else if (mif.ss_n != 2'b11) bad_ss = 1;
            else if (mif.busy) gap++;
            if (mif.busy) seen = 1;
            else if (seen) done = 1;
            if (!done) @(negedge clk);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL basic_timeout: got %b want 1", done);
        end
        checks++;
        if (lo !== 98) begin
            errors++; $display("FAIL basic_ss_low: got %0d want 98", lo);
        end
        checks++;
        if (gap !== 2) begin
            errors++; $display("FAIL basic_gap: got %0d want 2", gap);
        end
        checks++;
        if (bad_ss !== 1'b0) begin
            errors++; $display("FAIL basic_ss_onehot: got %b want 0", bad_ss);
        end
        checks++;
        if (m_dv - dv0 !== 1) begin
            errors++; $display("FAIL basic_dv_count: got %0d want 1", m_dv - dv0);
        end
        checks++;
        if (mif.data_rec !== 16'hA5C3) begin
            errors++; $display("FAIL basic_rec: got %h want a5c3", mif.data_rec);
        end
        checks++;
        if (mif.data_ch !== 1'b1) begin
            errors++; $display("FAIL basic_ch: got %h want 1", mif.data_ch);
        end
    endtask

    task automatic test_abort();
        int dv0;
        bit got = 0;
        m_word[0] = 16'h1234;
        @(negedge clk);
        mif.ch_sel = 1'b0;
        mif.en = 1'b1;
        @(negedge clk);
        mif.en = 1'b0;
        repeat (2 + 8 * 6 + 3) @(negedge clk);
        checks++;
        if (mif.busy !== 1'b1) begin
            errors++; $display("FAIL abort_busy_pre: got %b want 1", mif.busy);
        end
        dv0 = m_dv;
        rst = 1'b0;
        #1;
        checks++;
        if (mif.ss_n !== 2'b11) begin
            errors++; $display("FAIL abort_ss_n: got %b want 11", mif.ss_n);
        end
        checks++;
        if (mif.sclk !== 1'b1) begin
            errors++; $display("FAIL abort_sclk: got %b want 1", mif.sclk);
        end
        checks++;
        if (mif.busy !== 1'b0) begin
            errors++; $display("FAIL abort_busy: got %b want 0", mif.busy);
        end
        checks++;
        if (mif.data_rec !== 16'h0000) begin
            errors++; $display("FAIL abort_rec: got %h want 0000", mif.data_rec);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (120) @(negedge clk);
        checks++;
        if (m_dv - dv0 !== 0) begin
            errors++; $display("FAIL abort_no_dv: got %0d want 0", m_dv - dv0);
        end
        checks++;
        if (mif.data_rec !== 16'h0000) begin
            errors++; $display("FAIL abort_rec_hold: got %h want 0000", mif.data_rec);
        end
        @(negedge clk);
        mif.en = 1'b1;
        @(negedge clk);
        mif.en = 1'b0;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if (mif.data_valid) got = 1;
        end
        checks++;
        if (got !== 1'b1) begin
            errors++; $display("FAIL abort_refetch_timeout: got %b want 1", got);
        end
        checks++;
        if (mif.data_rec !== 16'h1234) begin
            errors++; $display("FAIL abort_refetch_rec: got %h want 1234", mif.data_rec);
        end
        checks++;
        if (mif.data_ch !== 1'b0) begin
            errors++; $display("FAIL abort_refetch_ch: got %h want 0", mif.data_ch);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int k = 0;
        int tprev = 0;
        logic [15:0] exp;
        bit idle = 0;
        m_word[0] = 16'h0001;
        m_word[1] = 16'hFFFF;
        @(negedge clk);
        mif.ch_sel = 1'b0;
        mif.en = 1'b1;
        for (int t = 0; t < 600 && k < 4; t++) begin
            @(negedge clk);
            if (mif.data_valid) begin
                exp = (k % 2 == 1) ? 16'hFFFF : 16'h0001;
                checks++;
                if (mif.data_ch !== 1'(k % 2)) begin
                    errors++;
                    $display("FAIL b2b_ch[%0d]: got %h want %0d", k, mif.data_ch, k % 2);
                end
                checks++;
                if (mif.data_rec !== exp) begin
                    errors++;
                    $display("FAIL b2b_rec[%0d]: got %h want %h", k, mif.data_rec, exp);
                end
                if (k > 0) begin
                    checks++;
                    if (cyc - tprev !== 101) begin
                        errors++;
                        $display("FAIL b2b_period[%0d]: got %0d want 101", k, cyc - tprev);
                    end
                end
                tprev = cyc;
                k++;
                mif.ch_sel = ~mif.ch_sel;
            end
        end
        checks++;
        if (k !== 4) begin
            errors++; $display("FAIL b2b_frames: got %0d want 4", k);
        end
        mif.en = 1'b0;
        for (int t = 0; t < 200 && !idle; t++) begin
            @(negedge clk);
            if (!mif.busy) idle = 1;
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++; $display("FAIL b2b_idle: got %b want 1", idle);
        end
    endtask

    task automatic test_modes();
        int dv0 [4];
        int e0 [4];
        int b0 [4];
        bit done = 0;
        logic exp_p;
        for (int g = 0; g < 4; g++) begin
            dv0[g] = sw_dv[g];
            e0[g]  = sw_edge[g];
            b0[g]  = sw_bad[g];
        end
        @(negedge clk);
        sw_en = 1'b1;
        @(negedge clk);
        sw_en = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (sw_busy == 4'b0000) done = 1;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL modes_timeout: got %b want 1", done);
        end
        for (int g = 0; g < 4; g++) begin
            exp_p = (g >= 2);
            checks++;
            if (sw_rec[g] !== 12'h5A3) begin
                errors++; $display("FAIL modes_rec[%0d]: got %h want 5a3", g, sw_rec[g]);
            end
            checks++;
            if (sw_dv[g] - dv0[g] !== 1) begin
                errors++;
                $display("FAIL modes_dv[%0d]: got %0d want 1", g, sw_dv[g] - dv0[g]);
            end
            checks++;
            if (sw_edge[g] - e0[g] !== 12) begin
                errors++;
                $display("FAIL modes_edges[%0d]: got %0d want 12", g, sw_edge[g] - e0[g]);
            end
            checks++;
            if (sw_bad[g] - b0[g] !== 0) begin
                errors++;
                $display("FAIL modes_idle_sclk[%0d]: got %0d want 0", g, sw_bad[g] - b0[g]);
            end
            checks++;
            if (sw_sclk[g] !== exp_p) begin
                errors++;
                $display("FAIL modes_sclk_end[%0d]: got %b want %b", g, sw_sclk[g], exp_p);
            end
        end
    endtask

    task automatic test_single_ch();
        int lo = 0;
        int dv0;
        bit seen = 0;
        bit done = 0;
        dv0 = o_dv;
        @(negedge clk);
        oif.ch_sel = 1'b1;
        oif.en = 1'b1;
        @(negedge clk);
        oif.en = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            if (oif.ss_n == 1'b0) lo++;
            if (oif.busy) seen = 1;
            else if (seen) done = 1;
            if (!done) @(negedge clk);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL one_timeout: got %b want 1", done);
        end
        checks++;
        if (lo !== 98) begin
            errors++; $display("FAIL one_ss_low: got %0d want 98", lo);
        end
        checks++;
        if (o_dv - dv0 !== 1) begin
            errors++; $display("FAIL one_dv: got %0d want 1", o_dv - dv0);
        end
        checks++;
        if (oif.data_ch !== 1'b0) begin
            errors++; $display("FAIL one_ch: got %h want 0", oif.data_ch);
        end
        checks++;
        if (oif.data_rec !== 16'h3C96) begin
            errors++; $display("FAIL one_rec: got %h want 3c96", oif.data_rec);
        end
    endtask

`ifdef SPI_RX_MOSI_EN
    task automatic test_mosi();
        int bad0;
        bit seen = 0;
        bit done = 0;
        bad0 = m_mosi_bad;
        @(negedge clk);
        mif.tx_word = 16'h8001;
        mif.ch_sel = 1'b0;
        mif.en = 1'b1;
        @(negedge clk);
        mif.en = 1'b0;
        mif.tx_word = 16'h0000;
        checks++;
        if (mif.mosi !== 1'b1) begin
            errors++; $display("FAIL mosi_lead_msb: got %b want 1", mif.mosi);
        end
        for (int t = 0; t < 200 && !done; t++) begin
            if (mif.busy) seen = 1;
            else if (seen) done = 1;
            if (!done) @(negedge clk);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL mosi_timeout: got %b want 1", done);
        end
        checks++;
        if (m_mosi_seq !== 16'h8001) begin
            errors++; $display("FAIL mosi_seq: got %h want 8001", m_mosi_seq);
        end
        checks++;
        if (m_mosi_bad - bad0 !== 0) begin
            errors++; $display("FAIL mosi_idle: got %0d want 0", m_mosi_bad - bad0);
        end
        checks++;
        if (mif.mosi !== 1'b0) begin
            errors++; $display("FAIL mosi_after: got %b want 0", mif.mosi);
        end
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mif.en = 1'b0;
        mif.ch_sel = 1'b0;
        oif.en = 1'b0;
        oif.ch_sel = 1'b0;
        m_word[0] = 16'h0000;
        m_word[1] = 16'h0000;
`ifdef SPI_RX_MOSI_EN
        mif.tx_word = 16'h0000;
        oif.tx_word = 16'h0000;
`endif
        #2 rst = 1'b0;
        test_reset();
        test_basic();
        test_abort();
        test_back_to_back();
        test_modes();
        test_single_ch();
`ifdef SPI_RX_MOSI_EN
        test_mosi();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
